// File: rtl/mvm_pkg.sv
// Shared definitions for the matrix-vector multiply engine.
// The ReLU clamp is selected in mvm_engine by the MVM_RELU_EN macro.
package mvm_pkg;

    localparam int N_ROWS = 4;
    localparam int ELEM_W = 4;
    localparam int VEC_W  = N_ROWS * ELEM_W;
    localparam int PROD_W = 2 * ELEM_W;
    localparam int SUM_W  = PROD_W + 2;

    // Instruction-level codes the surrounding pipeline uses to reach this block
    localparam logic [4:0] OPC_MVM     = 5'b11111;
    localparam logic [4:0] OPC_DIC     = 5'b11110;
    localparam logic [2:0] MEM_SRC_DIC = 3'b110;

    typedef enum logic {
        IDLE    = 1'b0,
        COMPUTE = 1'b1
    } state_t;

endpackage

// File: rtl/mvm_dot4.sv
// Combinational signed dot product of two packed 4-element vectors.
// Each product is 8-bit signed; the 4-term sum is 10-bit signed and cannot overflow.
module mvm_dot4
    import mvm_pkg::*;
(
    input  logic [VEC_W-1:0]        a_i,
    input  logic [VEC_W-1:0]        b_i,
    output logic signed [SUM_W-1:0] dot_o
);

    // Multiply element pairs and accumulate the sign-extended products
    always_comb begin
        logic signed [ELEM_W-1:0] ea;
        logic signed [ELEM_W-1:0] eb;
        logic signed [PROD_W-1:0] prod;
        dot_o = '0;
        ea    = '0;
        eb    = '0;
        prod  = '0;
        for (int unsigned c = 0; c < N_ROWS; c++) begin
            ea    = a_i[c*ELEM_W +: ELEM_W];
            eb    = b_i[c*ELEM_W +: ELEM_W];
            prod  = ea * eb;
            dot_o = dot_o + SUM_W'(prod);
        end
    end

endmodule

// File: rtl/mvm_engine.sv
// Matrix-vector multiply engine: 4x4 signed weight matrix times a 4-element
// vector, one result row per cycle. Define MVM_RELU_EN to clamp negative
// row sums to zero before they are written back.
module mvm_engine
    import mvm_pkg::*;
#(
    parameter int N_ROWS = mvm_pkg::N_ROWS,
    parameter int ELEM_W = mvm_pkg::ELEM_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       acc,
    input  logic                       acc_mode,
    input  logic [1:0]                 acc_sel,
    input  logic [N_ROWS*ELEM_W-1:0]   op_a,
    input  logic                       dic_rd,
    output logic [15:0]                dic_data,
    output logic                       busy,
    output logic                       stall
);

    localparam logic [1:0] LAST_ROW = 2'(N_ROWS - 1);

    state_t                      state_q;
    logic [1:0]                  row_q;
    logic                        busy_q;
    logic [N_ROWS*ELEM_W-1:0]    vec_q;
    logic [N_ROWS*ELEM_W-1:0]    w_q   [N_ROWS];
    logic [15:0]                 res_q [N_ROWS];

    logic signed [SUM_W-1:0]     dot;
    logic [15:0]                 res_d;
    logic                        load_cmd;
    logic                        start_cmd;

    assign load_cmd  = (state_q == IDLE) && acc &&  acc_mode;
    assign start_cmd = (state_q == IDLE) && acc && !acc_mode;

    mvm_dot4 u_dot4 (
        .a_i   (w_q[row_q]),
        .b_i   (vec_q),
        .dot_o (dot)
    );

    // Value written to the current result row
    always_comb begin
`ifdef MVM_RELU_EN
        res_d = dot[SUM_W-1] ? '0 : 16'(dot);
`else
        res_d = 16'(dot);
`endif
    end

    // Control FSM plus weight, vector and result storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            busy_q  <= 1'b0;
            vec_q   <= '0;
            for (int unsigned i = 0; i < N_ROWS; i++) begin
                w_q[i]   <= '0;
                res_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_cmd) begin
                        w_q[acc_sel] <= op_a;
                    end else if (start_cmd) begin
                        vec_q   <= op_a;
                        row_q   <= '0;
                        state_q <= COMPUTE;
                        busy_q  <= 1'b1;
                    end
                end
                COMPUTE: begin
                    res_q[row_q] <= res_d;
                    row_q        <= row_q + 2'd1;
                    if (row_q == LAST_ROW) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign stall    = busy_q & (acc | dic_rd);
    assign dic_data = res_q[acc_sel];

endmodule

// File: tb/tb_mvm_engine.sv
// Self-checking bench for mvm_engine: directed table of known matrices,
// randomized loads/computes against an integer model, and hand-written
// stall, back-to-back, simultaneous-command and mid-compute reset sequences.
module tb_mvm_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        acc;
    logic        acc_mode;
    logic [1:0]  acc_sel;
    logic [15:0] op_a;
    logic        dic_rd;
    logic [15:0] dic_data;
    logic        busy;
    logic        stall;

    int checks = 0;
    int errors = 0;

    // Reference model: weights and results as plain integers
    int mw [4][4];
    int mres [4];

    always #5 clk = ~clk;

    mvm_engine #(.N_ROWS(4), .ELEM_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .acc      (acc),
        .acc_mode (acc_mode),
        .acc_sel  (acc_sel),
        .op_a     (op_a),
        .dic_rd   (dic_rd),
        .dic_data (dic_data),
        .busy     (busy),
        .stall    (stall)
    );

    typedef struct {
        string           name;
        logic [3:0][15:0] w;
        logic [15:0]     x;
        logic [3:0][15:0] exp;
    } vec_t;

    vec_t tbl [3];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int elem(input logic [15:0] v, input int i);
        logic signed [3:0] e;
        e = v[4*i +: 4];
        return int'(e);
    endfunction

    function automatic void model_load(input int r, input logic [15:0] v);
        for (int c = 0; c < 4; c++) mw[r][c] = elem(v, c);
    endfunction

    function automatic void model_compute(input logic [15:0] x);
        for (int r = 0; r < 4; r++) begin
            int s;
            s = 0;
            for (int c = 0; c < 4; c++) s += mw[r][c] * elem(x, c);
`ifdef MVM_RELU_EN
            if (s < 0) s = 0;
`endif
            mres[r] = s;
        end
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < 4; r++) begin
            mres[r] = 0;
            for (int c = 0; c < 4; c++) mw[r][c] = 0;
        end
    endfunction

    task automatic load_row(input int r, input logic [15:0] v);
        acc = 1'b1; acc_mode = 1'b1; acc_sel = 2'(r); op_a = v;
        cyc();
        acc = 1'b0;
        model_load(r, v);
    endtask

    task automatic start(input logic [15:0] x);
        acc = 1'b1; acc_mode = 1'b0; op_a = x;
        cyc();
        acc = 1'b0;
        model_compute(x);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (busy && n < 20) begin
            n++;
            cyc();
        end
        check(name, 16'(n), 16'd4);
    endtask

    task automatic read_exp(input int r, input logic [15:0] exp, input string name);
        dic_rd = 1'b1; acc_sel = 2'(r);
        #1;
        check(name, dic_data, exp);
        dic_rd = 1'b0;
    endtask

    task automatic read_model(input int r, input string name);
        read_exp(r, 16'(mres[r]), name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] v1, v2;

        tbl[0].name = "identity";
        tbl[0].w    = {16'h1000, 16'h0100, 16'h0010, 16'h0001};
        tbl[0].x    = 16'h4321;
        tbl[0].exp  = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        tbl[1].name = "negative";
        tbl[1].w    = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        tbl[1].x    = 16'h7777;
`ifdef MVM_RELU_EN
        tbl[1].exp  = {16'h0000, 16'h0000, 16'h0000, 16'h0000};
`else
        tbl[1].exp  = {16'hFFE4, 16'hFFE4, 16'hFFE4, 16'hFFE4};
`endif
        tbl[2].name = "extreme";
        tbl[2].w    = {16'h8888, 16'h8888, 16'h8888, 16'h8888};
        tbl[2].x    = 16'h8888;
        tbl[2].exp  = {16'h0100, 16'h0100, 16'h0100, 16'h0100};

        model_reset();
        rst = 1'b1; acc = 1'b1; acc_mode = 1'b0; acc_sel = '0; op_a = '0; dic_rd = 1'b1;
        #12;
        check("reset_busy", {15'b0, busy}, 16'd0);
        check("reset_stall", {15'b0, stall}, 16'd0);
        acc = 1'b0; dic_rd = 1'b0;
        for (int r = 0; r < 4; r++) begin
            acc_sel = 2'(r);
            #1;
            check($sformatf("reset_res%0d", r), dic_data, 16'h0000);
        end
        cyc();
        rst = 1'b0;
        cyc();

        // Directed table
        for (int i = 0; i < 3; i++) begin
            for (int r = 0; r < 4; r++) load_row(r, tbl[i].w[r]);
            start(tbl[i].x);
            check($sformatf("%s_busy", tbl[i].name), {15'b0, busy}, 16'd1);
            wait_done($sformatf("%s_busy_len", tbl[i].name));
            for (int r = 0; r < 4; r++)
                read_exp(r, tbl[i].exp[r], $sformatf("%s_res%0d", tbl[i].name, r));
        end

        // Randomized loads and computes against the model
        for (int k = 0; k < 15; k++) begin
            int nl;
            int rr;
            nl = int'($urandom_range(1, 4));
            for (int j = 0; j < nl; j++) load_row(int'($urandom_range(0, 3)), 16'($urandom));
            rr = int'($urandom_range(0, 3));
            read_model(rr, $sformatf("rnd%0d_prev_res%0d", k, rr));
            start(16'($urandom));
            wait_done($sformatf("rnd%0d_busy_len", k));
            for (int r = 0; r < 4; r++) read_model(r, $sformatf("rnd%0d_res%0d", k, r));
        end

        // Read issued one cycle after start is held off until the compute ends
        load_row(0, 16'h1234); load_row(1, 16'h0F0F); load_row(2, 16'h7531); load_row(3, 16'hA1B2);
        start(16'h1111);
        wait_done("stall_pre_busy_len");
        start(16'h2222);
        cyc();
        dic_rd = 1'b1; acc_sel = 2'd2;
        #1;
        n = 0;
        while (stall && n < 20) begin
            n++;
            cyc();
        end
        check("stall_len", 16'(n), 16'd3);
        check("stall_busy_after", {15'b0, busy}, 16'd0);
        check("stall_read_new", dic_data, 16'(mres[2]));
        dic_rd = 1'b0;

        // Second start held through the whole compute, accepted when idle
        v1 = 16'h5A3C; v2 = 16'hC3A5;
        acc = 1'b1; acc_mode = 1'b0; op_a = v1;
        cyc();
        op_a = v2;
        n = 0;
        while (stall && n < 20) begin
            n++;
            cyc();
        end
        check("b2b_stall_len", 16'(n), 16'd4);
        cyc();
        acc = 1'b0;
        model_compute(v2);
        check("b2b_second_busy", {15'b0, busy}, 16'd1);
        wait_done("b2b_busy_len");
        for (int r = 0; r < 4; r++) read_model(r, $sformatf("b2b_res%0d", r));

        // Load and read presented together while idle: load happens, read still driven
        acc = 1'b1; acc_mode = 1'b1; acc_sel = 2'd1; op_a = 16'h3210; dic_rd = 1'b1;
        #1;
        check("simul_read", dic_data, 16'(mres[1]));
        cyc();
        acc = 1'b0; dic_rd = 1'b0;
        model_load(1, 16'h3210);
        start(16'h1F2E);
        wait_done("simul_busy_len");
        for (int r = 0; r < 4; r++) read_model(r, $sformatf("simul_res%0d", r));

        // Reset while computing row 2 aborts and clears everything
        start(16'h7654);
        cyc();
        cyc();
        #2;
        dic_rd = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_mid_busy", {15'b0, busy}, 16'd0);
        check("rst_mid_stall", {15'b0, stall}, 16'd0);
        dic_rd = 1'b0;
        model_reset();
        for (int r = 0; r < 4; r++) begin
            acc_sel = 2'(r);
            #1;
            check($sformatf("rst_mid_res%0d", r), dic_data, 16'h0000);
        end
        cyc();
        rst = 1'b0;
        cyc();
        start(16'h7777);
        wait_done("rst_post_busy_len");
        for (int r = 0; r < 4; r++) read_exp(r, 16'h0000, $sformatf("rst_post_w%0d", r));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
